// File: rtl/ascii_result_tx.sv
// Formats a 32-bit ALU result as ASCII decimal (optional '-', digits, terminator)
// and streams it byte by byte over the UART TX tx_start/tx_done handshake.
module ascii_result_tx #(
    parameter bit         SIGNED    = 1'b1,
    parameter logic [7:0] TERM_CHAR = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        tx_done,
    output logic [7:0]  d_out,
    output logic        tx_start,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_CONV, S_SEND, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {PH_SIGN, PH_DIG, PH_TERM} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [31:0]       mag_q, mag_d;
    logic              neg_q, neg_d;
    logic [9:0][3:0]   digits_q, digits_d;
    logic [3:0]        pidx_q, pidx_d;
    logic [3:0]        msd_q, msd_d;
    logic              found_q, found_d;
    logic [3:0]        didx_q, didx_d;
    logic              last_q, last_d;
    logic [7:0]        dout_q, dout_d;

    function automatic logic [31:0] pow10(input logic [3:0] i);
        case (i)
            4'd0:    return 32'd1;
            4'd1:    return 32'd10;
            4'd2:    return 32'd100;
            4'd3:    return 32'd1000;
            4'd4:    return 32'd10000;
            4'd5:    return 32'd100000;
            4'd6:    return 32'd1000000;
            4'd7:    return 32'd10000000;
            4'd8:    return 32'd100000000;
            4'd9:    return 32'd1000000000;
            default: return 32'd1;
        endcase
    endfunction

    logic [31:0] pow_cur;
    logic [7:0]  cur_byte;

    assign pow_cur = pow10(pidx_q);

    // Byte selected by the send pointer; loaded into dout_q when SEND ends.
    always_comb begin
        cur_byte = TERM_CHAR;
        case (phase_q)
            PH_SIGN: cur_byte = 8'h2D;
            PH_DIG:  cur_byte = 8'h30 + {4'h0, digits_q[didx_q]};
            default: cur_byte = TERM_CHAR;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        digits_d = digits_q;
        pidx_d   = pidx_q;
        msd_d    = msd_q;
        found_d  = found_q;
        didx_d   = didx_q;
        last_d   = last_q;
        dout_d   = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mag_d    = result;
                    neg_d    = 1'b0;
                    digits_d = '0;
                    pidx_d   = 4'd9;
                    msd_d    = 4'd0;
                    found_d  = 1'b0;
                    last_d   = 1'b0;
                    state_d  = S_ABS;
                end
            end
            S_ABS: begin
                if (SIGNED && mag_q[31]) begin
                    neg_d = 1'b1;
                    mag_d = ~mag_q + 32'd1;
                end
                state_d = S_CONV;
            end
            S_CONV: begin
                if (mag_q >= pow_cur) begin
                    mag_d            = mag_q - pow_cur;
                    digits_d[pidx_q] = digits_q[pidx_q] + 4'd1;
                    // First subtraction seen marks the most significant digit.
                    if (!found_q) begin
                        found_d = 1'b1;
                        msd_d   = pidx_q;
                    end
                end else if (pidx_q == 4'd0) begin
                    phase_d = neg_q ? PH_SIGN : PH_DIG;
                    didx_d  = msd_q;
                    state_d = S_SEND;
                end else begin
                    pidx_d = pidx_q - 4'd1;
                end
            end
            S_SEND: begin
                dout_d = cur_byte;
                last_d = (phase_q == PH_TERM);
                case (phase_q)
                    PH_SIGN: phase_d = PH_DIG;
                    PH_DIG: begin
                        if (didx_q == 4'd0) phase_d = PH_TERM;
                        else                didx_d  = didx_q - 4'd1;
                    end
                    default: phase_d = PH_TERM;
                endcase
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) state_d = last_q ? S_DONE : S_SEND;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SIGN;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            digits_q <= '0;
            pidx_q   <= 4'd9;
            msd_q    <= 4'd0;
            found_q  <= 1'b0;
            didx_q   <= 4'd0;
            last_q   <= 1'b0;
            dout_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            digits_q <= digits_d;
            pidx_q   <= pidx_d;
            msd_q    <= msd_d;
            found_q  <= found_d;
            didx_q   <= didx_d;
            last_q   <= last_d;
            dout_q   <= dout_d;
        end
    end

    assign tx_start = (state_q == S_SEND);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign d_out    = (state_q == S_SEND) ? cur_byte : dout_q;

endmodule

// File: tb/tb_ascii_result_tx.sv
// Directed bench for ascii_result_tx: a signed (index 0) and an unsigned (index 1)
// instance, each driven by a vector table plus hand-written reset/noise sequences.
module tb_ascii_result_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v   [2];
    logic [31:0] result_v  [2];
    logic        tx_done_v [2];
    logic [7:0]  d_out_v   [2];
    logic        tx_start_v[2];
    logic        busy_v    [2];
    logic        done_v    [2];

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ascii_result_tx #(.SIGNED(1'b1), .TERM_CHAR(8'd32)) u_s (
        .clk(clk), .reset(reset), .start(start_v[0]), .result(result_v[0]),
        .tx_done(tx_done_v[0]), .d_out(d_out_v[0]), .tx_start(tx_start_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    ascii_result_tx #(.SIGNED(1'b0), .TERM_CHAR(8'd32)) u_u (
        .clk(clk), .reset(reset), .start(start_v[1]), .result(result_v[1]),
        .tx_done(tx_done_v[1]), .d_out(d_out_v[1]), .tx_start(tx_start_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       exp;
        bit          noise;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int sel, input logic [31:0] val, input string exp, input bit noise);
        vec_t v;
        v.sel = sel; v.val = val; v.exp = exp; v.noise = noise;
        vq.push_back(v);
    endtask

    task automatic wait_tx(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_start_v[s]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Send one result and check the byte stream; abort_k >= 0 resets during that byte's WAIT.
    task automatic run_vec(input int s, input logic [31:0] val, input string exp,
                           input bit noise, input int abort_k);
        bit ok;
        if (noise) begin
            tx_done_v[s] = 1'b1;
            @(negedge clk);
            tx_done_v[s] = 1'b0;
            chk("idle tx_done no tx_start", tx_start_v[s], 0);
            chk("idle tx_done no busy", busy_v[s], 0);
            @(negedge clk);
        end
        result_v[s] = val;
        start_v[s]  = 1'b1;
        @(negedge clk);
        start_v[s]  = 1'b0;
        chk("busy after start", busy_v[s], 1);
        if (noise) begin
            result_v[s] = 32'd999;
            start_v[s]  = 1'b1;
            @(negedge clk);
            start_v[s]  = 1'b0;
            result_v[s] = val;
        end
        for (int k = 0; k < exp.len(); k++) begin
            if (k == 0) begin
                wait_tx(s, ok);
                chk("first tx_start timeout", ok, 1);
            end else begin
                chk($sformatf("tx_start latency byte %0d", k), tx_start_v[s], 1);
                if (!tx_start_v[s]) wait_tx(s, ok);
            end
            chk($sformatf("byte %0d of %0h", k, val), d_out_v[s], exp[k]);
            if (noise) tx_done_v[s] = 1'b1;
            @(negedge clk);
            tx_done_v[s] = 1'b0;
            for (int w = 0; w < 3; w++) begin
                chk("no tx_start in wait", tx_start_v[s], 0);
                chk("d_out stable in wait", d_out_v[s], exp[k]);
                chk("busy in wait", busy_v[s], 1);
                @(negedge clk);
            end
            if (k == abort_k) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("abort tx_start", tx_start_v[s], 0);
                chk("abort busy", busy_v[s], 0);
                chk("abort d_out", d_out_v[s], 0);
                for (int w = 0; w < 5; w++) begin
                    @(negedge clk);
                    chk("post abort quiet", tx_start_v[s], 0);
                end
                return;
            end
            tx_done_v[s] = 1'b1;
            @(negedge clk);
            tx_done_v[s] = 1'b0;
        end
        chk("done pulse", done_v[s], 1);
        chk("busy with done", busy_v[s], 1);
        chk("no tx_start at done", tx_start_v[s], 0);
        @(negedge clk);
        chk("done drops", done_v[s], 0);
        chk("busy drops", busy_v[s], 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add(0, 32'd0,          "0 ",            1'b0);
        add(0, 32'd12345,      "12345 ",        1'b0);
        add(0, 32'hFFFFFFF9,   "-7 ",           1'b0);
        add(1, 32'hFFFFFFFF,   "4294967295 ",   1'b0);
        add(0, 32'h80000000,   "-2147483648 ",  1'b0);
        add(1, 32'h80000000,   "2147483648 ",   1'b0);
        add(0, 32'h7FFFFFFF,   "2147483647 ",   1'b0);
        add(0, 32'd10,         "10 ",           1'b0);
        add(1, 32'd1000000000, "1000000000 ",   1'b0);
        add(0, 32'd12345,      "12345 ",        1'b1);
        add(1, 32'hFFFFFFF9,   "4294967289 ",   1'b1);

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; result_v[i] = '0; tx_done_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset d_out", d_out_v[i], 0);
            chk("reset tx_start", tx_start_v[i], 0);
            chk("reset busy", busy_v[i], 0);
            chk("reset done", done_v[i], 0);
        end
        reset = 1'b1;
        @(negedge clk);

        foreach (vq[i]) run_vec(vq[i].sel, vq[i].val, vq[i].exp, vq[i].noise, -1);

        run_vec(0, 32'd12345, "12345 ", 1'b0, 2);
        run_vec(0, 32'd9, "9 ", 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
